// File: rtl/edge_event_scheduler_pkg.sv
// Shared codes for the edge event scheduler: edge-select encodings, scheduler
// states and the channel-index width helper.
package edge_event_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  function automatic int ch_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward from
// ptr+1 (mod NUM_CH); ptr itself is the last candidate.
module rr_arbiter
  import edge_event_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]           req,
  input  logic [ch_idx_w(NUM_CH)-1:0] ptr,
  output logic [ch_idx_w(NUM_CH)-1:0] gnt_idx,
  output logic                        gnt_any
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  // Scan farthest-first so the nearest requester after ptr is written last and wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_CH]) begin
        gnt_idx = IDX_W'((int'(ptr) + k) % NUM_CH);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Per-channel edge detection with pending/overflow latches, drained one event at a
// time by a round-robin valid/ready scheduler. Optional drop counters: EES_DROP_CNT_EN.
module edge_event_scheduler
  import edge_event_pkg::*;
#(
  parameter int NUM_CH = 4
`ifdef EES_DROP_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         d,
  input  logic [2*NUM_CH-1:0]       edge_sel,
  input  logic [NUM_CH-1:0]         clear,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic                      evt_pol,
  output logic [NUM_CH-1:0]         pending,
`ifdef EES_DROP_CNT_EN
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt,
`endif
  output logic [NUM_CH-1:0]         overflow
);

  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] d_q;
  logic              armed_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] pol_q, pol_d;
  logic [NUM_CH-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  state_t            state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]  evt_ch_q, evt_ch_d;
  logic              evt_pol_q, evt_pol_d;

  logic [NUM_CH-1:0] rise, fall, hit, drop, acc_vec;
  logic              accept;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;

  // Edge detection and per-channel pending update: clear > new edge > acceptance.
  always_comb begin
    rise       = '0;
    fall       = '0;
    hit        = '0;
    drop       = '0;
    acc_vec    = '0;
    pending_d  = pending_q;
    pol_d      = pol_q;
    overflow_d = overflow_q;
    accept     = (state_q == S_OFFER) && evt_valid_q && evt_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      rise[i]    = armed_q & d[i] & ~d_q[i];
      fall[i]    = armed_q & ~d[i] & d_q[i];
      hit[i]     = enable & ((rise[i] & (edge_sel[2*i +: 2] inside {EDGE_RISE, EDGE_BOTH})) |
                             (fall[i] & (edge_sel[2*i +: 2] inside {EDGE_FALL, EDGE_BOTH})));
      acc_vec[i] = accept && (evt_ch_q == IDX_W'(i));
      if (clear[i]) begin
        pending_d[i]  = 1'b0;
        overflow_d[i] = 1'b0;
      end else if (hit[i]) begin
        if (pending_q[i] && !acc_vec[i]) begin
          drop[i]       = 1'b1;
          overflow_d[i] = 1'b1;
        end else begin
          pending_d[i] = 1'b1;
          pol_d[i]     = rise[i];
        end
      end else if (acc_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (pending_q),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_OFFER;
      S_OFFER: if (accept)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Offer fields are loaded on entry to OFFER and held until the handshake.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_pol_d   = evt_pol_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          evt_valid_d = 1'b1;
          evt_ch_d    = gnt_idx;
          evt_pol_d   = pol_q[gnt_idx];
        end
      end
      S_OFFER: begin
        if (accept) begin
          evt_valid_d = 1'b0;
          rr_ptr_d    = evt_ch_q;
        end
      end
      default: evt_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      d_q         <= '0;
      armed_q     <= 1'b0;
      pending_q   <= '0;
      pol_q       <= '0;
      overflow_q  <= '0;
      rr_ptr_q    <= '0;
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_pol_q   <= 1'b0;
    end else begin
      d_q         <= d;
      armed_q     <= 1'b1;
      pending_q   <= pending_d;
      pol_q       <= pol_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_pol_q   <= evt_pol_d;
    end
  end

`ifdef EES_DROP_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear[i])                                drop_cnt_d[i] = '0;
      else if (drop[i] && (drop_cnt_q[i] != '1))   drop_cnt_d[i] = drop_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_pol   = evt_pol_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed, table-driven bench for edge_event_scheduler (NUM_CH=4); drop-counter
// checks are included when EES_DROP_CNT_EN is defined.
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] d;
  logic [7:0] edge_sel;
  logic [3:0] clear;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_pol;
  logic [3:0] pending;
  logic [3:0] overflow;
`ifdef EES_DROP_CNT_EN
  logic [31:0] drop_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  edge_event_scheduler #(.NUM_CH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .d         (d),
    .edge_sel  (edge_sel),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_pol   (evt_pol),
    .pending   (pending),
`ifdef EES_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow)
  );

  typedef struct {
    logic [3:0] d;
    logic [7:0] sel;
    logic [3:0] clr;
    logic       en;
    logic       rdy;
    logic [3:0] e_pend;
    logic [3:0] e_ovf;
    logic       e_valid;
    logic [1:0] e_ch;
    logic       e_pol;
  } vec_t;

  vec_t vecs[40];

  function automatic vec_t mk(input logic [3:0] dd, input logic [7:0] sel, input logic [3:0] clr,
                              input logic en, input logic rdy, input logic [3:0] pend,
                              input logic [3:0] ovf, input logic val, input logic [1:0] ch,
                              input logic pol);
    vec_t v;
    v.d = dd; v.sel = sel; v.clr = clr; v.en = en; v.rdy = rdy;
    v.e_pend = pend; v.e_ovf = ovf; v.e_valid = val; v.e_ch = ch; v.e_pol = pol;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      d         = vecs[i].d;
      edge_sel  = vecs[i].sel;
      clear     = vecs[i].clr;
      enable    = vecs[i].en;
      evt_ready = vecs[i].rdy;
      tick();
      check($sformatf("row%0d pending", i),   32'(pending),   32'(vecs[i].e_pend));
      check($sformatf("row%0d overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      check($sformatf("row%0d evt_valid", i), 32'(evt_valid), 32'(vecs[i].e_valid));
      check($sformatf("row%0d evt_ch", i),    32'(evt_ch),    32'(vecs[i].e_ch));
      check($sformatf("row%0d evt_pol", i),   32'(evt_pol),   32'(vecs[i].e_pol));
    end
    clear = 4'b0000;
  endtask

  initial begin
    // Single rising edge on ch2, then one event on ch3 to park rr_ptr at 3.
    vecs[0]  = mk(4'b0000, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd0, 0);
    vecs[1]  = mk(4'b0100, 8'h55, 4'b0000, 1, 1, 4'b0100, 4'b0000, 0, 2'd0, 0);
    vecs[2]  = mk(4'b0100, 8'h55, 4'b0000, 1, 1, 4'b0100, 4'b0000, 1, 2'd2, 1);
    vecs[3]  = mk(4'b0100, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd2, 1);
    vecs[4]  = mk(4'b1100, 8'h55, 4'b0000, 1, 1, 4'b1000, 4'b0000, 0, 2'd2, 1);
    vecs[5]  = mk(4'b1100, 8'h55, 4'b0000, 1, 1, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[6]  = mk(4'b1100, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    // Three simultaneous edges drained ch0, ch1, ch3 with ready stalls.
    vecs[7]  = mk(4'b0000, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    vecs[8]  = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1011, 4'b0000, 0, 2'd3, 1);
    vecs[9]  = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1011, 4'b0000, 1, 2'd0, 1);
    vecs[10] = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1011, 4'b0000, 1, 2'd0, 1);
    vecs[11] = mk(4'b1011, 8'h55, 4'b0000, 1, 1, 4'b1010, 4'b0000, 0, 2'd0, 1);
    vecs[12] = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1010, 4'b0000, 1, 2'd1, 1);
    vecs[13] = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1010, 4'b0000, 1, 2'd1, 1);
    vecs[14] = mk(4'b1011, 8'h55, 4'b0000, 1, 1, 4'b1000, 4'b0000, 0, 2'd1, 1);
    vecs[15] = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[16] = mk(4'b1011, 8'h55, 4'b0000, 1, 0, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[17] = mk(4'b1011, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    // After granting ch3 the search wraps to ch0 first.
    vecs[18] = mk(4'b0000, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    vecs[19] = mk(4'b1001, 8'h55, 4'b0000, 1, 0, 4'b1001, 4'b0000, 0, 2'd3, 1);
    vecs[20] = mk(4'b1001, 8'h55, 4'b0000, 1, 0, 4'b1001, 4'b0000, 1, 2'd0, 1);
    vecs[21] = mk(4'b1001, 8'h55, 4'b0000, 1, 1, 4'b1000, 4'b0000, 0, 2'd0, 1);
    vecs[22] = mk(4'b1001, 8'h55, 4'b0000, 1, 1, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[23] = mk(4'b1001, 8'h55, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    // ch1 on both edges: the fall is dropped while pending, overflow sticks until clear.
    vecs[24] = mk(4'b1011, 8'h5D, 4'b0000, 1, 0, 4'b0010, 4'b0000, 0, 2'd3, 1);
    vecs[25] = mk(4'b1001, 8'h5D, 4'b0000, 1, 0, 4'b0010, 4'b0010, 1, 2'd1, 1);
    vecs[26] = mk(4'b1001, 8'h5D, 4'b0000, 1, 1, 4'b0000, 4'b0010, 0, 2'd1, 1);
    vecs[27] = mk(4'b1001, 8'h5D, 4'b0010, 1, 1, 4'b0000, 4'b0000, 0, 2'd1, 1);
    // Edge on ch1 in its acceptance cycle re-arms pending with the new polarity.
    vecs[28] = mk(4'b1011, 8'h5D, 4'b0000, 1, 0, 4'b0010, 4'b0000, 0, 2'd1, 1);
    vecs[29] = mk(4'b1011, 8'h5D, 4'b0000, 1, 0, 4'b0010, 4'b0000, 1, 2'd1, 1);
    vecs[30] = mk(4'b1001, 8'h5D, 4'b0000, 1, 1, 4'b0010, 4'b0000, 0, 2'd1, 1);
    vecs[31] = mk(4'b1001, 8'h5D, 4'b0000, 1, 0, 4'b0010, 4'b0000, 1, 2'd1, 0);
    vecs[32] = mk(4'b1001, 8'h5D, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0);
    // enable=0 gates ch0 toggles while pending ch3 still drains.
    vecs[33] = mk(4'b0001, 8'h5D, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 2'd1, 0);
    vecs[34] = mk(4'b1001, 8'h5D, 4'b0000, 1, 0, 4'b1000, 4'b0000, 0, 2'd1, 0);
    vecs[35] = mk(4'b1000, 8'h5D, 4'b0000, 0, 0, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[36] = mk(4'b1001, 8'h5D, 4'b0000, 0, 0, 4'b1000, 4'b0000, 1, 2'd3, 1);
    vecs[37] = mk(4'b1000, 8'h5D, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    vecs[38] = mk(4'b1001, 8'h5D, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);
    vecs[39] = mk(4'b1001, 8'h5D, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 2'd3, 1);

    rst = 1'b1; enable = 1'b1; d = 4'b0000; edge_sel = 8'h55; clear = 4'b0000; evt_ready = 1'b1;
    tick();
    check("reset pending",   32'(pending),   32'h0);
    check("reset overflow",  32'(overflow),  32'h0);
    check("reset evt_valid", 32'(evt_valid), 32'h0);
    check("reset evt_ch",    32'(evt_ch),    32'h0);
    check("reset evt_pol",   32'(evt_pol),   32'h0);
`ifdef EES_DROP_CNT_EN
    check("reset drop_cnt",  drop_cnt,       32'h0);
`endif
    rst = 1'b0;

    run_rows(0, 25);
`ifdef EES_DROP_CNT_EN
    check("drop_cnt ch1 after drop", 32'(drop_cnt[15:8]), 32'd1);
`endif
    run_rows(26, 39);
`ifdef EES_DROP_CNT_EN
    check("drop_cnt ch1 after clear", 32'(drop_cnt[15:8]), 32'd0);
`endif

    // Reset during an offer kills it; a high level at release is not an edge.
    d = 4'b1011; evt_ready = 1'b0;
    tick();
    check("pre-rst pending", 32'(pending), 32'b0010);
    tick();
    check("pre-rst evt_valid", 32'(evt_valid), 32'h1);
    check("pre-rst evt_ch",    32'(evt_ch),    32'h1);
    rst = 1'b1; d = 4'b1111;
    tick();
    check("mid-offer rst evt_valid", 32'(evt_valid), 32'h0);
    check("mid-offer rst pending",   32'(pending),   32'h0);
    check("mid-offer rst overflow",  32'(overflow),  32'h0);
    check("mid-offer rst evt_ch",    32'(evt_ch),    32'h0);
    check("mid-offer rst evt_pol",   32'(evt_pol),   32'h0);
    rst = 1'b0;
    tick();
    check("arm cycle pending", 32'(pending), 32'h0);
    tick();
    tick();
    check("post-release pending",   32'(pending),   32'h0);
    check("post-release evt_valid", 32'(evt_valid), 32'h0);

`ifdef EES_DROP_CNT_EN
    // Flood ch1 with edges while it stays pending: counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      d[1] = ~d[1];
      tick();
    end
    check("drop_cnt ch1 saturated", 32'(drop_cnt[15:8]), 32'd255);
    check("overflow ch1 flood",     32'(overflow),       32'b0010);
    clear = 4'b0010;
    tick();
    clear = 4'b0000;
    check("drop_cnt ch1 cleared", 32'(drop_cnt[15:8]), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
